// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core front end: fetch-queue entry layout
// and the architectural reset PC.
package mips_pkg;

   localparam int ENTRY_W = 96;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   // Entry layout, MSB to LSB: {pc, instr, pc_plus8}
   localparam int PC_LSB    = 64;
   localparam int INSTR_LSB = 32;
   localparam int PC8_LSB   = 0;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] pc,
                                                     input logic [31:0] instr,
                                                     input logic [31:0] pc_plus8);
      logic [ENTRY_W-1:0] e;
      e = '0;
      e[PC_LSB +: 32]    = pc;
      e[INSTR_LSB +: 32] = instr;
      e[PC8_LSB +: 32]   = pc_plus8;
      return e;
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, one asynchronous
// read port. Contents are don't-care after reset, so there is no reset.
module fq_storage
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [ENTRY_W-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [ENTRY_W-1:0]         rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID fetch queue: circular buffer of {pc, instr, pc_plus8} with a
// valid/ready handshake on both sides and a single-cycle redirect flush.
module if_fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_pc_plus8,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc_plus8,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               enq;
   logic               deq;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;

   // in_ready is purely a function of occupancy so the IFU PC enable never
   // sees a combinational path from the decode stall.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign enq       = in_valid && in_ready && !flush;
   assign deq       = out_valid && out_ready && !flush;
   assign wr_entry  = pack_entry(in_pc, in_instr, in_pc_plus8);

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (enq),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Head fields are masked while empty so stale entries never reach ID.
   always_comb begin
      out_pc       = '0;
      out_instr    = '0;
      out_pc_plus8 = '0;
      if (out_valid) begin
         out_pc       = rd_entry[PC_LSB +: 32];
         out_instr    = rd_entry[INSTR_LSB +: 32];
         out_pc_plus8 = rd_entry[PC8_LSB +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=2): hand-computed state checks
// plus a scoreboard that checks every entry ID consumes, in order.
module tb_if_fetch_queue;
   import mips_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [31:0] in_pc_plus8;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus8;
   logic        out_ready;
   logic        flush;
   logic [1:0]  count;

   int n_checks = 0;
   int n_fail   = 0;
   int model_count = 0;
   logic [31:0] exp_q [$];

   if_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_pc        (in_pc),
      .in_instr     (in_instr),
      .in_pc_plus8  (in_pc_plus8),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_pc_plus8 (out_pc_plus8),
      .out_ready    (out_ready),
      .flush        (flush),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'h2400_0000 | {16'h0000, pc[15:0]};
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model,
   // and return 2 time units after the edge with outputs settled.
   task automatic applyStimulus(input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic fl);
      logic enq;
      logic deq;
      in_valid    = iv;
      in_pc       = pc;
      in_instr    = instr_of(pc);
      in_pc_plus8 = pc + 32'd8;
      out_ready   = ordy;
      flush       = fl;
      @(posedge clk);
      enq = iv && (model_count != DEPTH) && !fl;
      deq = (model_count != 0) && ordy && !fl;
      if (fl) begin
         exp_q.delete();
         model_count = 0;
      end else begin
         if (enq) exp_q.push_back(pc);
         model_count = model_count + int'(enq) - int'(deq);
      end
      #2;
   endtask

   task automatic checkOutput(input string name, input int exp_count, input logic exp_valid,
                              input logic exp_ready, input logic [31:0] exp_pc);
      compare({name, ".count"}, 32'(count), 32'(exp_count));
      compare({name, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
      compare({name, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
      compare({name, ".out_pc"}, out_pc, exp_pc);
      compare({name, ".out_instr"}, out_instr, exp_valid ? instr_of(exp_pc) : 32'h0);
      compare({name, ".out_pc_plus8"}, out_pc_plus8, exp_valid ? exp_pc + 32'd8 : 32'h0);
   endtask

   // Scoreboard monitor: every head ID consumes must be the oldest expected entry.
   initial begin
      logic [31:0] exp_pc;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready && !flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL sb_underflow: got pc 0x%08h, expected no entry at %0t", out_pc, $time);
            end else begin
               exp_pc = exp_q.pop_front();
               compare("sb.pc", out_pc, exp_pc);
               compare("sb.instr", out_instr, instr_of(exp_pc));
               compare("sb.pc_plus8", out_pc_plus8, exp_pc + 32'd8);
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("[TB] FAIL timeout: simulation did not finish, required end before 100000");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_pc       = '0;
      in_instr    = '0;
      in_pc_plus8 = '0;
      out_ready   = 1'b0;
      flush       = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      checkOutput("reset", 0, 1'b0, 1'b1, 32'h0);

      // Fill with ID stalled; third offer must be refused
      applyStimulus(1'b1, RESET_PC, 1'b0, 1'b0);
      checkOutput("fill1", 1, 1'b1, 1'b1, 32'h3000);
      applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0);
      checkOutput("fill2", 2, 1'b1, 1'b0, 32'h3000);
      applyStimulus(1'b1, 32'h3008, 1'b0, 1'b0);
      checkOutput("fill_refused", 2, 1'b1, 1'b0, 32'h3000);

      // Full plus dequeue: no enqueue because in_ready was low
      applyStimulus(1'b1, 32'h300C, 1'b1, 1'b0);
      checkOutput("full_deq", 1, 1'b1, 1'b1, 32'h3004);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("drain1", 0, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("empty_deq", 0, 1'b0, 1'b1, 32'h0);

      // Streaming at one entry per cycle
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, RESET_PC + 32'(4 * k), 1'b1, 1'b0);
         checkOutput("stream", 1, 1'b1, 1'b1, RESET_PC + 32'(4 * k));
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream_drain", 0, 1'b0, 1'b1, 32'h0);

      // Flush with simultaneous enqueue and dequeue
      applyStimulus(1'b1, 32'h3100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h3104, 1'b0, 1'b0);
      checkOutput("pre_flush", 2, 1'b1, 1'b0, 32'h3100);
      applyStimulus(1'b1, 32'h3010, 1'b1, 1'b1);
      checkOutput("flush", 0, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b1, 32'h4000, 1'b0, 1'b0);
      checkOutput("redirect", 1, 1'b1, 1'b1, 32'h4000);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("redirect_drain", 0, 1'b0, 1'b1, 32'h0);

      // Asynchronous reset between edges while full
      applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h5004, 1'b0, 1'b0);
      checkOutput("pre_async", 2, 1'b1, 1'b0, 32'h5000);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 0, 1'b0, 1'b1, 32'h0);
      exp_q.delete();
      model_count = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0);
      checkOutput("post_reset", 1, 1'b1, 1'b1, 32'h6000);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("post_reset_drain", 0, 1'b0, 1'b1, 32'h0);

      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the IF stage and the ID stage of the pipelined MIPS core. It buffers up to DEPTH fetched entries {pc, instr, pc_plus8} under a valid/ready handshake, so a decode stall does not stall PC update until the queue is full. A redirect flush (taken branch, j/jal, jr) discards all buffered wrong-path entries in one cycle.

## Interface
- DEPTH, 2: number of entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  IFU presents a fetched entry this cycle.
- in_pc  in  32  PC of the fetched instruction.
- in_instr  in  32  instruction word.
- in_pc_plus8  in  32  link address (PC+8).
- in_ready  out  1  queue can accept an entry; drives the IFU PC enable.
- out_valid  out  1  head entry is valid for ID.
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction.
- out_pc_plus8  out  32  head link address.
- out_ready  in  1  ID consumes the head this cycle (not stalled).
- flush  in  1  redirect; discard every entry and the same-cycle enqueue.
- count  out  log2(DEPTH)+1  occupancy, 0..DEPTH.

## Operation
- Circular buffer: write pointer wr_ptr, read pointer rd_ptr, both log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in the count register.
- in_ready = (count != DEPTH). It depends only on state and has no combinational path from out_ready.
- Enqueue fires when in_valid && in_ready && !flush: write the entry at wr_ptr and increment wr_ptr.
- Dequeue fires when out_valid && out_ready && !flush: increment rd_ptr.
- count next value: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- out_valid = (count != 0). The out_* data fields are read combinationally from entry[rd_ptr].
- When count == 0 the out_* data fields are forced to 0, so no stale data is visible.
- Flush has priority over everything else. On the next edge:
  - count = 0 and wr_ptr = rd_ptr = 0.
  - Any same-cycle enqueue and dequeue are ignored.
- No bypass: an entry enqueued into an empty queue becomes visible on the following cycle.
- Full plus simultaneous dequeue: in_ready is already 0, so there is no enqueue. The result is count = DEPTH-1 and in_ready = 1 next cycle.
- Empty plus out_ready: no effect.
- in_valid while !in_ready: the entry is not taken. The IFU holds its PC because in_ready gates its enable.

## Timing
- Reset (asynchronous assert, synchronous-style release on the first edge after deassert):
  - count = 0, pointers = 0.
  - out_valid = 0, out_pc = out_instr = out_pc_plus8 = 0.
  - in_ready = 1.
  - Storage contents are don't-care.
- Reset mid-operation: all buffered entries are lost immediately, with no partial states.
- Latency from enqueue to out_valid is 1 cycle. Sustained throughput is 1 entry per cycle when out_ready is held at 1.
- The cycle after a flush edge: out_valid = 0 and in_ready = 1. The IFU's redirected PC may enqueue in that cycle.
- All state changes happen on the rising clk edge only.

## Structure
- Shared package mips_pkg holds:
  - the entry width constant (96 bits = pc, instr, pc_plus8);
  - the reset PC constant 32'h00003000, already used by the IFU;
  - field offset constants for packing and unpacking an entry.
- One natural sub-module: fq_storage, a DEPTH×96 register array with one write port and one asynchronous read port, no reset. Pointer and count control stays in if_fetch_queue.

## Test plan
- Reset then idle: hold rst_n = 0 for 3 cycles, then release -> count = 0, out_valid = 0, in_ready = 1, out_pc = 0.
- Fill (DEPTH = 2):
  - Enqueue pc 0x3000 then 0x3004 with out_ready = 0 -> count = 2 and in_ready = 0.
  - A third in_valid (pc 0x3008) is not accepted.
  - out_pc stays 0x3000.
- Streaming: in_valid and out_ready held at 1 for 10 cycles with pc 0x3000 + 4k -> out_pc sequence 0x3000, 0x3004, … in order, one per cycle after the initial 1-cycle latency, count constant at 1.
- Full plus dequeue: count = 2, out_ready = 1, in_valid = 1 -> next cycle count = 1, in_ready = 1, out_pc = 0x3004. The third entry is not enqueued.
- Flush with simultaneous traffic: count = 2, flush = 1 together with in_valid = 1 (pc 0x3010) and out_ready = 1 -> next cycle count = 0, out_valid = 0. Then enqueue pc 0x4000 -> out_pc = 0x4000 one cycle later.
- Asynchronous reset mid-fill: rst_n drops between edges with count = 2 -> out_valid = 0 and count = 0 immediately, without waiting for a clock edge.
